// File: rtl/fcn_pkg.sv
// Shared definitions for the sequential fully-connected MAC layer:
// FSM state encoding and a width helper.
package fcn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_DRAIN,
    ST_OUTPUT
  } state_e;

  // Ceiling log2, clamped to 1 so that counters and addresses never get zero width.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fcn_mac_lane.sv
// One MAC lane: accumulator with bias preload, signed multiply-accumulate
// (wrapping two's complement) and an optional ReLU on the output.
module fcn_mac_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_i,
  input  logic signed [ACC_WIDTH-1:0]  bias_i,
  input  logic                         mac_en_i,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  input  logic signed [DATA_WIDTH-1:0] w_i,
  input  logic                         relu_i,
  output logic        [ACC_WIDTH-1:0]  y_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;

  assign prod = x_i * w_i;

  generate
    if (PW >= ACC_WIDTH) begin : g_trunc
      assign prod_ext = prod[ACC_WIDTH-1:0];
    end else begin : g_sext
      assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    end
  endgenerate

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = bias_i;
    end else if (mac_en_i) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign y_o = (relu_i && acc_q[ACC_WIDTH-1]) ? '0 : acc_q;

endmodule

// File: rtl/fcn_seq_mac.sv
// Sequential fully-connected layer: buffers an N-element input vector, then
// computes M outputs LANES at a time against an external weight memory.
module fcn_seq_mac
  import fcn_pkg::*;
#(
  parameter int M          = 8,
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int LANES      = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic                                   relu_en,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [DATA_WIDTH-1:0]                  in_data,
  input  logic [ACC_WIDTH*M-1:0]                 bias_flat,
  output logic [clog2((M/LANES)*N)-1:0]          w_addr,
  input  logic [DATA_WIDTH*LANES-1:0]            w_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [ACC_WIDTH*LANES-1:0]             out_data,
  output logic                                   out_last,
  output logic                                   busy,
  output logic                                   done
);

  localparam int G  = M / LANES;
  localparam int AW = clog2(G * N);
  localparam int CW = clog2(N);
  localparam int GW = clog2(G);

  state_e                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [GW-1:0]                g_q, g_d;
  logic                         relu_q, relu_d;
  logic                         done_q, done_d;
  logic                         bias_ld;
  logic [AW-1:0]                w_addr_q;
  logic [AW-1:0]                cur_addr;
  logic                         mac_en_q;
  logic signed [DATA_WIDTH-1:0] x_q;
  logic signed [DATA_WIDTH-1:0] elem_q [N];

  logic cnt_last;
  logic g_last;

  assign cnt_last = (cnt_q == CW'(N - 1));
  assign g_last   = (g_q == GW'(G - 1));
  assign cur_addr = AW'(int'(g_q) * N + int'(cnt_q));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    g_d     = g_q;
    relu_d  = relu_q;
    done_d  = 1'b0;
    bias_ld = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          g_d     = '0;
          relu_d  = relu_en;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          if (cnt_last) begin
            state_d = ST_COMPUTE;
            cnt_d   = '0;
            bias_ld = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        if (cnt_last) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          if (g_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_COMPUTE;
            g_d     = g_q + 1'b1;
            bias_ld = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      g_q      <= '0;
      relu_q   <= 1'b0;
      done_q   <= 1'b0;
      w_addr_q <= '0;
      mac_en_q <= 1'b0;
      x_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      g_q      <= g_d;
      relu_q   <= relu_d;
      done_q   <= done_d;
      // Weight data returns one cycle after the address, so the operand and
      // MAC enable are delayed to line up with it.
      mac_en_q <= (state_q == ST_COMPUTE);
      x_q      <= elem_q[cnt_q];
      if (state_q == ST_COMPUTE) begin
        w_addr_q <= cur_addr;
      end
    end
  end

  // NOTE: the input buffer is a plain memory with no reset; it is always fully
  // rewritten in LOAD before being read.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD && in_valid) begin
      elem_q[cnt_q] <= $signed(in_data);
    end
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [ACC_WIDTH-1:0] lane_bias;
      logic        [ACC_WIDTH-1:0] lane_y;

      assign lane_bias = bias_flat[(int'(g_d) * LANES + l) * ACC_WIDTH +: ACC_WIDTH];

      fcn_mac_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (bias_ld),
        .bias_i   (lane_bias),
        .mac_en_i (mac_en_q),
        .x_i      (x_q),
        .w_i      ($signed(w_data[l*DATA_WIDTH +: DATA_WIDTH])),
        .relu_i   (relu_q),
        .y_o      (lane_y)
      );

      assign out_data[l*ACC_WIDTH +: ACC_WIDTH] = lane_y;
    end
  endgenerate

  assign w_addr    = (state_q == ST_COMPUTE) ? cur_addr : w_addr_q;
  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_OUTPUT);
  assign out_last  = (state_q == ST_OUTPUT) && g_last;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule
